branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Multi-cycle branch resolution stage. Sits downstream of instruction decode and drives the PC load path.
- On a branch start it latches the IR fields and R[Ra], and evaluates the C2 condition against R[Ra].
- It computes the target PC+sext(C) and issues a one-cycle PC load when the branch is taken.
- It keeps saturating taken and not-taken counters for debug readout.

Parameters:
- CNT_W, 16, width of each taken / not-taken statistics counter.
- OFF_W, 19, width of the immediate C field (IR[18:0]), sign-extended to 32.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the control unit: branch instruction is in IR; ignored unless in IDLE.
- ir  in  32  instruction register. C2 is ir[22:19] and C is ir[OFF_W-1:0].
- ra_value  in  32  contents of R[Ra], valid in the cycle start is high.
- pc  in  32  already-incremented PC (PC+1), valid in the cycle start is high.
- busy  out  1  high in every state except IDLE.
- con  out  1  registered branch condition result; holds until the next evaluation.
- pc_load  out  1  one-cycle strobe to load pc_next into the PC.
- pc_next  out  32  branch target.
- done  out  1  one-cycle strobe marking completion, taken or not.
- taken_cnt  out  CNT_W  saturating count of taken branches.
- ntaken_cnt  out  CNT_W  saturating count of not-taken branches.

Behaviour:
- Reset (clear=0, asynchronous):
  - State goes to IDLE.
  - busy, con, pc_load, done = 0.
  - pc_next = 32'h0.
  - Both counters = 0.
- FSM states: IDLE, EVAL, TARGET, COMMIT.
- IDLE, start=1: latch pc, ra_value, ir[22:19] and the C field into internal registers, then go to EVAL.
- EVAL: compute con from the latched values, keyed on c2[1:0]. c2[3:2] are ignored.
  - 00 (zero): con = (R[Ra] == 0).
  - 01 (nonzero): con = (R[Ra] != 0).
  - 10 (positive): con = ~R[Ra][31]. Zero counts as positive.
  - 11 (negative): con = R[Ra][31].
  - Register con; next state TARGET.
- TARGET: pc_next <= latched_pc + {{(32-OFF_W){C[OFF_W-1]}}, C}. The add is modulo 2^32 and wraps silently. Next state COMMIT.
- COMMIT:
  - done=1 for exactly this cycle.
  - pc_load = con for this cycle.
  - Increment taken_cnt if con=1, else ntaken_cnt. Each saturates at all-ones and does not wrap.
  - Next state IDLE.
- Latency: start at cycle N gives done/pc_load at cycle N+3. A back-to-back start is accepted at N+4 at the earliest.
- start while busy=1 is ignored: no queuing, and the latched operands are not disturbed.
- Input changes on ir, ra_value and pc after the start cycle have no effect on the branch in flight.
- pc_next and con hold their last values after COMMIT. They are updated only in TARGET and EVAL respectively.
- pc_load and done are never high outside COMMIT.
- clear asserted mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - No pc_load is emitted for the aborted branch.
  - Counters are cleared.

Test Plan:
- Branch if zero: c2=0000, ra_value=0, pc=0x10, C=0x00005 -> con=1, pc_next=0x15, pc_load=1 and done=1 in cycle N+3, taken_cnt=1.
- Branch if nonzero on zero: c2=0001, ra_value=0, C=0x00005 -> con=0, pc_load=0, done=1 at N+3, ntaken_cnt=1. pc_next is still computed as 0x15.
- Negative offset and sign test: c2=0011, ra_value=0x80000000, pc=0x20, C=0x7FFFC (-4) -> con=1, pc_next=0x1C. Also c2=0010 with ra_value=0 -> con=1 (zero counts as positive).
- Wrap and ignored upper C2 bits: c2=1110, ra_value=0x7FFFFFFF, pc=0xFFFFFFFE, C=0x00003 -> con=1, pc_next=0x00000001.
- Busy-ignore: pulse start again at N+1 with different ir/ra_value -> the first branch's results are unchanged and exactly one done strobe occurs. A new start at N+4 is accepted.
- Saturation and reset: with CNT_W=2, complete 5 taken branches -> taken_cnt=3. Assert clear during EVAL of the next branch -> no pc_load, all outputs and counters 0, and the FSM accepts a start on the first cycle after release.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Branch resolve unit bus: decode-side request
// and PC-load / debug-counter response.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [31:0]      ir;
  logic [31:0]      ra_value;
  logic [31:0]      pc;
  logic             busy;
  logic             con;
  logic             pc_load;
  logic [31:0]      pc_next;
  logic             done;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] ntaken_cnt;

  modport master (
    output start, ir, ra_value, pc,
    input  busy, con, pc_load, pc_next, done,
    input  taken_cnt, ntaken_cnt
  );

  modport slave (
    input  start, ir, ra_value, pc,
    output busy, con, pc_load, pc_next, done,
    output taken_cnt, ntaken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Multi-cycle branch resolution: condition eval,
// target add, one-cycle PC load on taken branch.
module branch_resolve_unit #(
  parameter int CNT_W = 16,
  parameter int OFF_W = 19
) (
  input logic clock,
  input logic clear,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    TARGET,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0]      lat_pc;
  logic [31:0]      lat_ra;
  logic [1:0]       lat_c2;
  logic [OFF_W-1:0] lat_c;
  logic             con;
  logic [31:0]      pc_next;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] ntaken_cnt;
  logic [31:0]      offset;

  // c2[3:2] and the opcode bits carry no meaning here
  logic unused_ir;
  assign unused_ir = ^bus.ir[31:21];

  assign offset = {{(32-OFF_W){lat_c[OFF_W-1]}}, lat_c};

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing; start is only honoured in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = EVAL;
      EVAL:    state_nxt = TARGET;
      TARGET:  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, condition, target and debug counters
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      lat_pc     <= '0;
      lat_ra     <= '0;
      lat_c2     <= '0;
      lat_c      <= '0;
      con        <= 1'b0;
      pc_next    <= '0;
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            lat_pc <= bus.pc;
            lat_ra <= bus.ra_value;
            lat_c2 <= bus.ir[20:19];
            lat_c  <= bus.ir[OFF_W-1:0];
          end
        end
        EVAL: begin
          unique case (lat_c2)
            2'b00: con <= (lat_ra == 32'h0);
            2'b01: con <= (lat_ra != 32'h0);
            2'b10: con <= ~lat_ra[31];
            2'b11: con <= lat_ra[31];
            default: con <= 1'b0;
          endcase
        end
        TARGET: pc_next <= lat_pc + offset;
        COMMIT: begin
          if (con) begin
            if (!(&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
          end else begin
            if (!(&ntaken_cnt)) ntaken_cnt <= ntaken_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == COMMIT);
  assign bus.pc_load    = (state == COMMIT) & con;
  assign bus.con        = con;
  assign bus.pc_next    = pc_next;
  assign bus.taken_cnt  = taken_cnt;
  assign bus.ntaken_cnt = ntaken_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit:
// directed cases, random branches, saturation, clear.
module tb_branch_resolve_unit;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic clear = 1'b0;

  always #5 clock = ~clock;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .CNT_W(CNT_W),
    .OFF_W(19)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  int          m_taken  = 0;
  int          m_ntaken = 0;
  logic        m_con    = 1'b0;
  logic [31:0] m_pcn    = 32'h0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_con(input logic [3:0] c2,
                                   input logic [31:0] ra);
    int signed s;
    s = ra;
    case (c2 % 4)
      0: return s == 0;
      1: return s != 0;
      2: return s >= 0;
      default: return s < 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc,
                                             input logic [18:0] c);
    longint off;
    longint sum;
    off = longint'(c);
    if (off >= (1 << 18)) off = off - (1 << 19);
    sum = longint'(pc) + off;
    return sum[31:0];
  endfunction

  task automatic scramble();
    bus.ir       = $urandom;
    bus.ra_value = $urandom;
    bus.pc       = $urandom;
  endtask

  // Caller is at a negedge; returns at the N+4 negedge.
  task automatic run_branch(input logic [3:0]  c2,
                            input logic [31:0] ra,
                            input logic [31:0] pc,
                            input logic [18:0] c,
                            input bit          poke);
    logic        e_con;
    logic [31:0] e_pcn;
    logic [8:0]  top;
    top          = 9'($urandom);
    e_con        = ref_con(c2, ra);
    e_pcn        = ref_target(pc, c);
    bus.start    = 1'b1;
    bus.ir       = {top, c2, c};
    bus.ra_value = ra;
    bus.pc       = pc;
    @(negedge clock);
    bus.start = poke;
    scramble();
    chk("n1_busy", 32'(bus.busy), 32'd1);
    chk("n1_done", 32'(bus.done), 32'd0);
    chk("n1_con_hold", 32'(bus.con), 32'(m_con));
    @(negedge clock);
    bus.start = 1'b0;
    scramble();
    chk("n2_done", 32'(bus.done), 32'd0);
    chk("n2_load", 32'(bus.pc_load), 32'd0);
    chk("n2_con", 32'(bus.con), 32'(e_con));
    chk("n2_pcn_hold", bus.pc_next, m_pcn);
    @(negedge clock);
    scramble();
    chk("n3_done", 32'(bus.done), 32'd1);
    chk("n3_load", 32'(bus.pc_load), 32'(e_con));
    chk("n3_pcn", bus.pc_next, e_pcn);
    chk("n3_tcnt", 32'(bus.taken_cnt), 32'(m_taken));
    chk("n3_ncnt", 32'(bus.ntaken_cnt), 32'(m_ntaken));
    if (e_con) m_taken  = (m_taken  < CMAX) ? m_taken + 1  : CMAX;
    else       m_ntaken = (m_ntaken < CMAX) ? m_ntaken + 1 : CMAX;
    m_con = e_con;
    m_pcn = e_pcn;
    @(negedge clock);
    chk("n4_busy", 32'(bus.busy), 32'd0);
    chk("n4_done", 32'(bus.done), 32'd0);
    chk("n4_load", 32'(bus.pc_load), 32'd0);
    chk("n4_tcnt", 32'(bus.taken_cnt), 32'(m_taken));
    chk("n4_ncnt", 32'(bus.ntaken_cnt), 32'(m_ntaken));
    chk("n4_pcn", bus.pc_next, m_pcn);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_con"}, 32'(bus.con), 32'd0);
    chk({tag, "_load"}, 32'(bus.pc_load), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_pcn"}, bus.pc_next, 32'h0);
    chk({tag, "_tcnt"}, 32'(bus.taken_cnt), 32'd0);
    chk({tag, "_ncnt"}, 32'(bus.ntaken_cnt), 32'd0);
  endtask

  initial begin
    logic [3:0]  rc2;
    logic [31:0] rra;
    bus.start    = 1'b0;
    bus.ir       = '0;
    bus.ra_value = '0;
    bus.pc       = '0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("rst");
    clear = 1'b1;
    @(negedge clock);

    run_branch(4'b0000, 32'h0, 32'h10, 19'h00005, 1'b0);
    chk("bz_taken", 32'(bus.taken_cnt), 32'd1);
    run_branch(4'b0001, 32'h0, 32'h10, 19'h00005, 1'b0);
    chk("bnz_pcn", bus.pc_next, 32'h15);
    run_branch(4'b0011, 32'h80000000, 32'h20, 19'h7FFFC, 1'b0);
    chk("neg_pcn", bus.pc_next, 32'h1C);
    run_branch(4'b0010, 32'h0, $urandom, 19'($urandom), 1'b0);
    chk("pos_zero_con", 32'(bus.con), 32'd1);
    run_branch(4'b1110, 32'h7FFFFFFF, 32'hFFFFFFFE, 19'h00003, 1'b0);
    chk("wrap_pcn", bus.pc_next, 32'h1);

    run_branch(4'b0001, 32'h5, 32'h100, 19'h00010, 1'b1);
    run_branch(4'b0000, 32'h5, 32'h200, 19'h00001, 1'b1);

    for (int i = 0; i < 5; i++)
      run_branch(4'b0000, 32'h0, $urandom, 19'($urandom), 1'b0);
    chk("sat_taken", 32'(bus.taken_cnt), 32'd3);

    for (int i = 0; i < 24; i++) begin
      rc2 = 4'($urandom);
      rra = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_branch(rc2, rra, $urandom, 19'($urandom),
                 1'($urandom_range(0, 1)));
    end

    bus.start    = 1'b1;
    bus.ir       = {9'h0, 4'b0000, 19'h00004};
    bus.ra_value = 32'h0;
    bus.pc       = 32'h40;
    @(negedge clock);
    bus.start = 1'b0;
    chk("clr_in_eval", 32'(bus.busy), 32'd1);
    clear = 1'b0;
    #1;
    chk_reset_outputs("clr");
    @(negedge clock);
    chk("clr_no_load", 32'(bus.pc_load), 32'd0);
    @(negedge clock);
    chk("clr_no_done", 32'(bus.done), 32'd0);
    m_taken  = 0;
    m_ntaken = 0;
    m_con    = 1'b0;
    m_pcn    = 32'h0;
    clear    = 1'b1;
    run_branch(4'b0000, 32'h0, 32'h40, 19'h00004, 1'b0);
    chk("post_clr_pcn", bus.pc_next, 32'h44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
